uart_word_link: RTL and testbench

//  Parametrised word<->byte bridge between the debug unit and a byte-wide UART (tx_start/tx_done, rx_valid).
//  TX: buffers debug words in a FIFO and serialises each word to the UART, one byte at a time.
//  RX: assembles UART bytes into words, with an inter-byte timeout.

---
 rtl/uart_word_link.sv | 275 +++++++++++++++++++++++++++
 tb/tb_uart_word_link.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_word_link.sv
// uart_word_link: word<->byte bridge between the debug unit and a byte-wide UART.
// TX buffers debug words in a FIFO and serialises each one bytewise over a
// start/done handshake. RX assembles UART bytes into words and drops a partial
// word after RX_TIMEOUT idle cycles.
// Optional feature macro: UART_WORD_LINK_CHECKSUM_EN appends an XOR checksum byte
// to every TX word and expects and verifies one after every RX word.
module uart_word_link #(
  parameter int unsigned WORD_BYTES = 4,
  parameter int unsigned TX_DEPTH   = 4,
  parameter int unsigned MSB_FIRST  = 0,
  parameter int unsigned RX_TIMEOUT = 50000,
  parameter int unsigned TMO_W      = 16
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic [8*WORD_BYTES-1:0]       i_word_data,
  input  logic                          i_word_valid,
  output logic                          o_word_ready,
  output logic [$clog2(TX_DEPTH+1)-1:0] o_tx_fifo_count,
  output logic [7:0]                    o_tx_byte,
  output logic                          o_tx_start,
  input  logic                          i_tx_done,
  output logic                          o_tx_busy,
  output logic                          o_tx_word_done,
  input  logic [7:0]                    i_rx_byte,
  input  logic                          i_rx_valid,
  output logic [8*WORD_BYTES-1:0]       o_rx_word,
  output logic                          o_rx_word_valid,
  output logic                          o_rx_timeout,
  output logic                          o_rx_csum_err
);
  localparam int unsigned W   = 8 * WORD_BYTES;
  localparam int unsigned CW  = $clog2(TX_DEPTH + 1);
  localparam int unsigned PW  = $clog2(TX_DEPTH);
  localparam int unsigned TIW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
`ifdef UART_WORD_LINK_CHECKSUM_EN
  localparam int unsigned RX_N = WORD_BYTES + 1;
`else
  localparam int unsigned RX_N = WORD_BYTES;
`endif
  localparam int unsigned RIW = $clog2(RX_N + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((RX_TIMEOUT == 0) ? 0 : RX_TIMEOUT - 1);

  // Byte k of a word in wire order.
  function automatic logic [7:0] byte_of(input logic [W-1:0] w, input int unsigned k);
    logic [W-1:0] sh;
    sh = w >> (8 * ((MSB_FIRST != 0) ? (WORD_BYTES - 1 - k) : k));
    return sh[7:0];
  endfunction

`ifdef UART_WORD_LINK_CHECKSUM_EN
  function automatic logic [7:0] word_xor(input logic [W-1:0] w);
    logic [7:0] x;
    x = '0;
    for (int unsigned k = 0; k < WORD_BYTES; k++) x = x ^ byte_of(w, k);
    return x;
  endfunction
`endif

  // ---------------------------------------------------------------- TX FIFO
  logic [W-1:0]  fifo_mem_q [TX_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          push, pop;

  assign o_word_ready    = (count_q != CW'(TX_DEPTH));
  assign push            = i_word_valid && o_word_ready;
  assign o_tx_fifo_count = count_q;

  // Word storage; occupancy lives in the pointers, so no reset is needed here.
  always_ff @(posedge i_clock) begin
    if (push) fifo_mem_q[wr_ptr_q] <= i_word_data;
  end

  // Pointer and occupancy tracking; power-of-2 depth makes the wrap implicit.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (pop && !push) count_q <= count_q - CW'(1);
    end
  end

  // ----------------------------------------------------------------- TX FSM
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT,
`ifdef UART_WORD_LINK_CHECKSUM_EN
    ST_CSUM,
    ST_CWAIT,
`endif
    ST_LAST
  } tx_state_e;

  tx_state_e      state_q, state_d;
  logic [W-1:0]   tx_word_q;
  logic [TIW-1:0] tx_idx_q;
  logic [7:0]     tx_byte_q;
  logic           last_byte;

  assign last_byte = (tx_idx_q == TIW'(WORD_BYTES - 1));
  assign o_tx_byte = tx_byte_q;

  // State register.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state: one start per byte, advance only on the UART done pulse.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (count_q != '0) state_d = ST_SEND;
      ST_SEND: state_d = ST_WAIT;
      ST_WAIT: begin
        if (i_tx_done) begin
          if (!last_byte) state_d = ST_SEND;
`ifdef UART_WORD_LINK_CHECKSUM_EN
          else            state_d = ST_CSUM;
`else
          else            state_d = ST_LAST;
`endif
        end
      end
`ifdef UART_WORD_LINK_CHECKSUM_EN
      ST_CSUM:  state_d = ST_CWAIT;
      ST_CWAIT: if (i_tx_done) state_d = ST_LAST;
`endif
      ST_LAST: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State-decoded outputs and the FIFO pop request.
  always_comb begin
    pop            = (state_q == ST_IDLE) && (count_q != '0);
    o_tx_busy      = (state_q != ST_IDLE);
    o_tx_word_done = (state_q == ST_LAST);
`ifdef UART_WORD_LINK_CHECKSUM_EN
    o_tx_start     = (state_q == ST_SEND) || (state_q == ST_CSUM);
`else
    o_tx_start     = (state_q == ST_SEND);
`endif
  end

  // TX datapath: the byte register is loaded one cycle ahead of the start pulse
  // so o_tx_byte is already stable when o_tx_start rises.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      tx_word_q <= '0;
      tx_idx_q  <= '0;
      tx_byte_q <= '0;
    end else if (pop) begin
      tx_word_q <= fifo_mem_q[rd_ptr_q];
      tx_idx_q  <= '0;
      tx_byte_q <= byte_of(fifo_mem_q[rd_ptr_q], 0);
    end else if ((state_q == ST_WAIT) && i_tx_done) begin
      if (!last_byte) begin
        tx_idx_q  <= tx_idx_q + TIW'(1);
        tx_byte_q <= byte_of(tx_word_q, 32'(tx_idx_q) + 1);
      end
`ifdef UART_WORD_LINK_CHECKSUM_EN
      else begin
        tx_byte_q <= word_xor(tx_word_q);
      end
`endif
    end
  end

  // --------------------------------------------------------------------- RX
  logic [RIW-1:0]   rx_idx_q, rx_idx_d;
  logic [W-1:0]     rx_buf_q, rx_buf_d;
  logic [W-1:0]     rx_word_q, rx_word_d;
  logic [TMO_W-1:0] rx_tmr_q, rx_tmr_d;
  logic             rx_valid_q, rx_valid_d;
  logic             rx_tmo_q, rx_tmo_d;
  int unsigned      rx_shift;
`ifdef UART_WORD_LINK_CHECKSUM_EN
  logic [7:0]       rx_csum_q, rx_csum_d;
  logic             rx_err_q, rx_err_d;
`endif

  assign rx_shift = 8 * ((MSB_FIRST != 0) ? (WORD_BYTES - 1 - 32'(rx_idx_q)) : 32'(rx_idx_q));

  // RX next state: an arriving byte always takes priority over timer expiry.
  always_comb begin
    rx_idx_d   = rx_idx_q;
    rx_buf_d   = rx_buf_q;
    rx_word_d  = rx_word_q;
    rx_tmr_d   = rx_tmr_q;
    rx_valid_d = 1'b0;
    rx_tmo_d   = 1'b0;
`ifdef UART_WORD_LINK_CHECKSUM_EN
    rx_csum_d  = rx_csum_q;
    rx_err_d   = 1'b0;
`endif
    if (i_rx_valid) begin
      rx_tmr_d = '0;
      if (rx_idx_q < RIW'(WORD_BYTES)) begin
        rx_buf_d = (rx_buf_q & ~(W'(8'hFF) << rx_shift)) | (W'(i_rx_byte) << rx_shift);
`ifdef UART_WORD_LINK_CHECKSUM_EN
        rx_csum_d = (rx_idx_q == '0) ? i_rx_byte : (rx_csum_q ^ i_rx_byte);
`endif
      end
      if (rx_idx_q == RIW'(RX_N - 1)) begin
        rx_idx_d = '0;
`ifdef UART_WORD_LINK_CHECKSUM_EN
        if (i_rx_byte == rx_csum_q) begin
          rx_word_d  = rx_buf_q;
          rx_valid_d = 1'b1;
        end else begin
          rx_err_d   = 1'b1;
        end
`else
        rx_word_d  = rx_buf_d;
        rx_valid_d = 1'b1;
`endif
      end else begin
        rx_idx_d = rx_idx_q + RIW'(1);
      end
    end else if ((RX_TIMEOUT != 0) && (rx_idx_q != '0)) begin
      if (rx_tmr_q == TMO_LAST) begin
        rx_idx_d = '0;
        rx_tmr_d = '0;
        rx_tmo_d = 1'b1;
      end else begin
        rx_tmr_d = rx_tmr_q + TMO_W'(1);
      end
    end
  end

  // RX registers.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      rx_idx_q   <= '0;
      rx_buf_q   <= '0;
      rx_word_q  <= '0;
      rx_tmr_q   <= '0;
      rx_valid_q <= 1'b0;
      rx_tmo_q   <= 1'b0;
`ifdef UART_WORD_LINK_CHECKSUM_EN
      rx_csum_q  <= '0;
      rx_err_q   <= 1'b0;
`endif
    end else begin
      rx_idx_q   <= rx_idx_d;
      rx_buf_q   <= rx_buf_d;
      rx_word_q  <= rx_word_d;
      rx_tmr_q   <= rx_tmr_d;
      rx_valid_q <= rx_valid_d;
      rx_tmo_q   <= rx_tmo_d;
`ifdef UART_WORD_LINK_CHECKSUM_EN
      rx_csum_q  <= rx_csum_d;
      rx_err_q   <= rx_err_d;
`endif
    end
  end

  assign o_rx_word       = rx_word_q;
  assign o_rx_word_valid = rx_valid_q;
  assign o_rx_timeout    = rx_tmo_q;
`ifdef UART_WORD_LINK_CHECKSUM_EN
  assign o_rx_csum_err   = rx_err_q;
`else
  assign o_rx_csum_err   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_word_link.sv
// Testbench for uart_word_link: random TX/RX words against a byte-stream model,
// a UART stand-in answering each start with done 10 cycles later, FIFO full,
// RX timeout boundary and mid-word reset.
module tb_uart_word_link;
  localparam int unsigned WB    = 4;
  localparam int unsigned W     = 8 * WB;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned MSBF  = 0;
  localparam int unsigned TMO   = 20;
  localparam int unsigned CW    = $clog2(DEPTH + 1);
`ifdef UART_WORD_LINK_CHECKSUM_EN
  localparam int unsigned CS = 1;
`else
  localparam int unsigned CS = 0;
`endif

  logic          clk = 1'b0;
  logic          i_reset;
  logic [W-1:0]  i_word_data;
  logic          i_word_valid;
  logic          o_word_ready;
  logic [CW-1:0] o_tx_fifo_count;
  logic [7:0]    o_tx_byte;
  logic          o_tx_start;
  logic          i_tx_done;
  logic          o_tx_busy;
  logic          o_tx_word_done;
  logic [7:0]    i_rx_byte;
  logic          i_rx_valid;
  logic [W-1:0]  o_rx_word;
  logic          o_rx_word_valid;
  logic          o_rx_timeout;
  logic          o_rx_csum_err;

  always #5 clk = ~clk;

  uart_word_link #(
    .WORD_BYTES(WB), .TX_DEPTH(DEPTH), .MSB_FIRST(MSBF), .RX_TIMEOUT(TMO), .TMO_W(16)
  ) dut (
    .i_clock(clk), .i_reset(i_reset),
    .i_word_data(i_word_data), .i_word_valid(i_word_valid), .o_word_ready(o_word_ready),
    .o_tx_fifo_count(o_tx_fifo_count), .o_tx_byte(o_tx_byte), .o_tx_start(o_tx_start),
    .i_tx_done(i_tx_done), .o_tx_busy(o_tx_busy), .o_tx_word_done(o_tx_word_done),
    .i_rx_byte(i_rx_byte), .i_rx_valid(i_rx_valid), .o_rx_word(o_rx_word),
    .o_rx_word_valid(o_rx_word_valid), .o_rx_timeout(o_rx_timeout), .o_rx_csum_err(o_rx_csum_err)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------- reference model
  // Wire order: byte k of the word goes k-th on the line.
  function automatic logic [7:0] wire_byte(input logic [W-1:0] w, input int unsigned k);
    logic [W-1:0] t;
    t = w >> (8 * ((MSBF != 0) ? (WB - 1 - k) : k));
    return t[7:0];
  endfunction

  function automatic logic [7:0] xor_bytes(input logic [W-1:0] w);
    logic [7:0] x;
    x = 8'h00;
    for (int unsigned k = 0; k < WB; k++) x ^= wire_byte(w, k);
    return x;
  endfunction

  logic [7:0]   exp_tx_q[$];
  logic [W-1:0] last_rx_word = '0;

  task automatic model_push(input logic [W-1:0] w);
    for (int unsigned k = 0; k < WB; k++) exp_tx_q.push_back(wire_byte(w, k));
    if (CS != 0) exp_tx_q.push_back(xor_bytes(w));
  endtask

  // ------------------------------------------------------------ UART stand-in
  int unsigned uart_cnt   = 0;
  bit          uart_stall = 1'b0;
  logic [7:0]  uart_cur   = '0;
  int unsigned done_cnt   = 0;

  initial begin
    i_tx_done = 1'b0;
    forever begin
      @(negedge clk);
      i_tx_done = 1'b0;
      if (!i_reset) begin
        uart_cnt = 0;
        continue;
      end
      if (uart_cnt != 0 && !uart_stall) begin
        uart_cnt--;
        if (uart_cnt == 0) begin
          i_tx_done = 1'b1;
          done_cnt++;
          check_eq("tx_byte_stable", o_tx_byte, uart_cur);
        end
      end
      if (o_tx_start) begin
        check_eq("tx_start_while_busy", uart_cnt != 0, 0);
        uart_cur = o_tx_byte;
        check_eq("tx_byte_expected", exp_tx_q.size() != 0, 1);
        if (exp_tx_q.size() != 0) check_eq("tx_byte", o_tx_byte, exp_tx_q.pop_front());
        uart_cnt = 10;
      end
    end
  end

  // Pulse counters.
  int unsigned wd_cnt = 0, tmo_cnt = 0;
  initial forever begin
    @(negedge clk);
    if (o_tx_word_done) wd_cnt++;
    if (o_rx_timeout)   tmo_cnt++;
  end

  // ---------------------------------------------------------------- stimulus
  task automatic push_word(input logic [W-1:0] w);
    int unsigned guard;
    guard = 0;
    i_word_data  = w;
    i_word_valid = 1'b1;
    while (!o_word_ready && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check_eq("push_ready", o_word_ready, 1);
    model_push(w);
    @(negedge clk);
    i_word_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int unsigned guard;
    guard = 0;
    while (!(exp_tx_q.size() == 0 && !o_tx_busy && uart_cnt == 0) && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    check_eq(tag, guard < 5000, 1);
    @(negedge clk);
  endtask

  task automatic send_rx(input logic [7:0] b);
    i_rx_byte  = b;
    i_rx_valid = 1'b1;
    @(negedge clk);
    i_rx_valid = 1'b0;
  endtask

  task automatic rx_send_word(input logic [W-1:0] w, input int unsigned max_gap);
    for (int unsigned k = 0; k < WB + CS; k++) begin
      send_rx((k < WB) ? wire_byte(w, k) : xor_bytes(w));
      if (k != WB + CS - 1) repeat ($urandom_range(0, max_gap)) @(negedge clk);
    end
    check_eq("rx_valid", o_rx_word_valid, 1);
    check_eq("rx_word", o_rx_word, w);
    check_eq("rx_no_timeout", o_rx_timeout, 0);
    last_rx_word = w;
    @(negedge clk);
    check_eq("rx_valid_pulse", o_rx_word_valid, 0);
  endtask

  task automatic check_reset(input string p);
    check_eq({p, "_ready"}, o_word_ready, 1);
    check_eq({p, "_count"}, o_tx_fifo_count, 0);
    check_eq({p, "_start"}, o_tx_start, 0);
    check_eq({p, "_byte"}, o_tx_byte, 0);
    check_eq({p, "_busy"}, o_tx_busy, 0);
    check_eq({p, "_wdone"}, o_tx_word_done, 0);
    check_eq({p, "_rxword"}, o_rx_word, 0);
    check_eq({p, "_rxvalid"}, o_rx_word_valid, 0);
    check_eq({p, "_rxtmo"}, o_rx_timeout, 0);
    check_eq({p, "_csumerr"}, o_rx_csum_err, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned wd0, tmo0, d0, guard;
    logic [7:0] b0, b1, b2, b3;
    logic [W-1:0] wexp;
    i_reset = 1'b0; i_word_data = '0; i_word_valid = 1'b0;
    i_rx_byte = '0; i_rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("rst");
    i_reset = 1'b1;
    @(negedge clk);

    // T1: single word, byte order and start latency
    wd0 = wd_cnt;
    push_word(32'hDDCCBBAA);
    check_eq("t1_start_early", o_tx_start, 0);
    @(negedge clk);
    check_eq("t1_start_latency", o_tx_start, 1);
    check_eq("t1_first_byte", o_tx_byte, (MSBF != 0) ? 8'hDD : 8'hAA);
    wait_drain("t1_drain");
    check_eq("t1_word_done", wd_cnt - wd0, 1);

    // Random words with random gaps
    wd0 = wd_cnt;
    for (int i = 0; i < 10; i++) begin
      push_word($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_drain("rnd_drain");
    check_eq("rnd_word_done", wd_cnt - wd0, 10);
    check_eq("rnd_count_empty", o_tx_fifo_count, 0);

    // T3: FIFO full while the UART stalls
    uart_stall = 1'b1;
    wd0 = wd_cnt;
    for (int i = 0; i < DEPTH + 1; i++) push_word($urandom);
    @(negedge clk);
    check_eq("t3_count_full", o_tx_fifo_count, DEPTH);
    check_eq("t3_not_ready", o_word_ready, 0);
    i_word_data = $urandom; i_word_valid = 1'b1;
    repeat (3) @(negedge clk);
    i_word_valid = 1'b0;
    check_eq("t3_reject_count", o_tx_fifo_count, DEPTH);
    uart_stall = 1'b0;
    wait_drain("t3_drain");
    check_eq("t3_word_done", wd_cnt - wd0, DEPTH + 1);

    // T2-style fixed pattern: wire bytes 12,34,56,78 (LSB first)
    rx_send_word((MSBF != 0) ? 32'h12345678 : 32'h78563412, 0);
    // Random RX words, gaps up to the last cycle before expiry
    for (int i = 0; i < 8; i++) rx_send_word($urandom, TMO - 1);

    // T4: timeout after exactly TMO idle cycles
    tmo0 = tmo_cnt;
    send_rx(8'h55); send_rx(8'h66);
    for (int i = 1; i <= TMO; i++) begin
      @(negedge clk);
      if (i == TMO - 1) check_eq("t4_tmo_early", o_rx_timeout, 0);
      if (i == TMO)     check_eq("t4_tmo_pulse", o_rx_timeout, 1);
    end
    @(negedge clk);
    check_eq("t4_tmo_count", tmo_cnt - tmo0, 1);
    check_eq("t4_word_kept", o_rx_word, last_rx_word);
    rx_send_word(32'h04030201, 0);

    // Byte arriving in the expiry cycle wins
    tmo0 = tmo_cnt;
    b0 = $urandom; b1 = $urandom; b2 = $urandom; b3 = $urandom;
    send_rx(b0); send_rx(b1);
    repeat (TMO - 1) @(negedge clk);
    send_rx(b2);
    check_eq("bnd_no_tmo", o_rx_timeout, 0);
    send_rx(b3);
    wexp = '0;
    wexp = (MSBF != 0) ? {b0, b1, b2, b3} : {b3, b2, b1, b0};
    if (CS != 0) send_rx(b0 ^ b1 ^ b2 ^ b3);
    check_eq("bnd_valid", o_rx_word_valid, 1);
    check_eq("bnd_word", o_rx_word, wexp);
    last_rx_word = wexp;
    check_eq("bnd_tmo_count", tmo_cnt - tmo0, 0);

`ifdef UART_WORD_LINK_CHECKSUM_EN
    // T5: checksum byte on TX, good and bad checksum on RX
    push_word(32'h01020304);
    wait_drain("t5_drain");
    rx_send_word(32'h01020304, 0);
    send_rx(8'h04); send_rx(8'h03); send_rx(8'h02); send_rx(8'h01); send_rx(8'hFF);
    check_eq("t5_csum_err", o_rx_csum_err, 1);
    check_eq("t5_no_valid", o_rx_word_valid, 0);
    check_eq("t5_word_kept", o_rx_word, 32'h01020304);
`endif

    // T6: reset after the second byte of a word, with a partial RX word pending
    d0 = done_cnt;
    push_word($urandom);
    guard = 0;
    while (done_cnt < d0 + 2 && guard < 500) begin
      @(posedge clk);
      guard++;
    end
    check_eq("t6_two_bytes", done_cnt >= d0 + 2, 1);
    @(negedge clk);
    i_rx_byte = 8'hA5; i_rx_valid = 1'b1;
    @(posedge clk);
    #1;
    i_rx_valid = 1'b0;
    i_reset = 1'b0;
    exp_tx_q.delete();
    @(negedge clk);
    check_reset("t6");
    i_reset = 1'b1;
    @(negedge clk);
    wd0 = wd_cnt;
    push_word($urandom);
    wait_drain("t6_drain");
    check_eq("t6_word_done", wd_cnt - wd0, 1);
    last_rx_word = '0;
    rx_send_word($urandom, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
